// File: rtl/init_value_bank.sv
// Multi-channel constant source: every channel holds INIT out of reset and is
// rewritten through a small request FIFO, each request carrying a drive delay.
module init_value_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int INIT     = 42,
  parameter int DLY_W    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         reload,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CW-1:0]                wr_chan,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [DLY_W-1:0]             wr_delay,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [CHANNELS-1:0]          out_changed,
  output logic                         err,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, next_state;

  logic [CW-1:0]    mem_chan [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DLY_W-1:0] mem_dly  [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             empty, full, push, pop, apply;

  logic [CW-1:0]    hold_chan;
  logic [WIDTH-1:0] hold_data;
  logic [DLY_W-1:0] cnt;
  logic [WIDTH-1:0] chan_q [CHANNELS];

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign wr_ready = !full && !reload;
  assign push     = wr_valid && wr_ready;
  assign busy     = !empty || (state != S_IDLE);

  // Pops look at the pre-edge FIFO contents, so a same-edge push is never popped.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    apply      = 1'b0;
    if (reload) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            apply = 1'b1;
            if (!empty) pop = 1'b1;
            else        next_state = S_IDLE;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_chan[wr_ptr[AW-1:0]] <= wr_chan;
      mem_data[wr_ptr[AW-1:0]] <= wr_data;
      mem_dly[wr_ptr[AW-1:0]]  <= wr_delay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (reload) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_chan <= '0;
      hold_data <= '0;
      cnt       <= '0;
    end else if (pop) begin
      hold_chan <= mem_chan[rd_ptr[AW-1:0]];
      hold_data <= mem_data[rd_ptr[AW-1:0]];
      cnt       <= mem_dly[rd_ptr[AW-1:0]];
    end else if (!reload && state == S_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) chan_q[c] <= INIT_V;
      out_changed <= '0;
      err         <= 1'b0;
    end else begin
      out_changed <= '0;
      err         <= 1'b0;
      if (reload) begin
        for (int c = 0; c < CHANNELS; c++) chan_q[c] <= INIT_V;
        out_changed <= '1;
      end else if (apply) begin
        if ({1'b0, hold_chan} < CH_LIM) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (hold_chan == CW'(c)) begin
              chan_q[c]      <= hold_data;
              out_changed[c] <= 1'b1;
            end
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = chan_q[g];
  end

endmodule

// File: tb/tb_init_value_bank.sv
// Bench for init_value_bank: a 4-channel and a 3-channel instance share all
// inputs; a request-schedule reference model predicts both every cycle.
module tb_init_value_bank;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reload = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_chan = '0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_delay = '0;

  logic        wr_ready4, err4, busy4;
  logic [127:0] out_data4;
  logic [3:0]  out_changed4;
  logic        wr_ready3, err3, busy3;
  logic [95:0] out_data3;
  logic [2:0]  out_changed3;

  always #5 clk = ~clk;

  init_value_bank #(.WIDTH(32), .CHANNELS(4), .DEPTH(DEPTH), .INIT(42), .DLY_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .reload(reload), .wr_valid(wr_valid), .wr_ready(wr_ready4),
    .wr_chan(wr_chan), .wr_data(wr_data), .wr_delay(wr_delay), .out_data(out_data4),
    .out_changed(out_changed4), .err(err4), .busy(busy4));

  init_value_bank #(.WIDTH(32), .CHANNELS(3), .DEPTH(DEPTH), .INIT(42), .DLY_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .reload(reload), .wr_valid(wr_valid), .wr_ready(wr_ready3),
    .wr_chan(wr_chan), .wr_data(wr_data), .wr_delay(wr_delay), .out_data(out_data3),
    .out_changed(out_changed3), .err(err3), .busy(busy3));

  typedef struct { logic [1:0] chan; logic [31:0] data; int delay; } req_t;

  int tests = 0;
  int fails = 0;

  // reference model: queued requests plus the one in flight and its apply edge
  req_t        mq[$];
  bit          hv;
  req_t        hreq;
  int          h_apply;
  int          edge_n;
  logic [31:0] m4 [4];
  logic [31:0] m3 [3];
  logic [3:0]  c4;
  logic [2:0]  c3;
  logic        e3;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hv = 0;
    edge_n = 0;
    for (int c = 0; c < 4; c++) m4[c] = 32'd42;
    for (int c = 0; c < 3; c++) m3[c] = 32'd42;
    c4 = '0; c3 = '0; e3 = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] ch, input logic [31:0] d,
                            input logic [7:0] dl, input bit rl);
    int pre;
    bit can_pop;
    req_t r;
    c4 = '0; c3 = '0; e3 = 1'b0;
    if (rl) begin
      for (int c = 0; c < 4; c++) m4[c] = 32'd42;
      for (int c = 0; c < 3; c++) m3[c] = 32'd42;
      mq.delete();
      hv = 0;
      c4 = '1; c3 = '1;
    end else begin
      pre = mq.size();
      can_pop = !hv;
      if (hv && h_apply == edge_n) begin
        m4[hreq.chan] = hreq.data;
        c4[hreq.chan] = 1'b1;
        if (hreq.chan < 3) begin
          m3[hreq.chan] = hreq.data;
          c3[hreq.chan] = 1'b1;
        end else e3 = 1'b1;
        hv = 0;
        can_pop = 1;
      end
      if (can_pop && pre > 0) begin
        hreq = mq.pop_front();
        hv = 1;
        h_apply = edge_n + hreq.delay + 1;
      end
      if (v && pre < DEPTH) begin
        r.chan = ch; r.data = d; r.delay = int'(dl);
        mq.push_back(r);
      end
    end
    edge_n++;
  endtask

  task automatic check_regs();
    logic [127:0] x4;
    logic [95:0]  x3;
    for (int c = 0; c < 4; c++) x4[c*32 +: 32] = m4[c];
    for (int c = 0; c < 3; c++) x3[c*32 +: 32] = m3[c];
    chk("data4", out_data4, x4);
    chk("changed4", {124'd0, out_changed4}, {124'd0, c4});
    chk("err4", {127'd0, err4}, 128'd0);
    chk("data3", {32'd0, out_data3}, {32'd0, x3});
    chk("changed3", {125'd0, out_changed3}, {125'd0, c3});
    chk("err3", {127'd0, err3}, {127'd0, e3});
  endtask

  task automatic cycle(input bit v, input logic [1:0] ch, input logic [31:0] d,
                       input logic [7:0] dl, input bit rl);
    bit exp_ready, exp_busy;
    wr_valid = v; wr_chan = ch; wr_data = d; wr_delay = dl; reload = rl;
    exp_ready = !rl && (mq.size() < DEPTH);
    exp_busy  = (mq.size() > 0) || hv;
    #1;
    chk("wr_ready4", {127'd0, wr_ready4}, {127'd0, exp_ready});
    chk("wr_ready3", {127'd0, wr_ready3}, {127'd0, exp_ready});
    chk("busy4", {127'd0, busy4}, {127'd0, exp_busy});
    chk("busy3", {127'd0, busy3}, {127'd0, exp_busy});
    @(posedge clk);
    model_edge(v, ch, d, dl, rl);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
  endtask

  initial begin
    req_t burst [5];
    int idx;
    int budget;
    bit acc;

    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_regs();
    idle(2);

    // single write, zero delay
    cycle(1'b1, 2'd2, 32'h1234, 8'd0, 1'b0);
    idle(2);
    chk("ch2_after_e2", {96'd0, out_data4[95:64]}, {96'd0, 32'h1234});
    chk("pulse_after_e2", {124'd0, out_changed4}, {124'd0, 4'b0100});
    idle(3);

    // delayed write
    cycle(1'b1, 2'd1, 32'd7, 8'd5, 1'b0);
    idle(6);
    chk("ch1_held_e6", {96'd0, out_data4[63:32]}, {96'd0, 32'd42});
    idle(1);
    chk("ch1_after_e7", {96'd0, out_data4[63:32]}, {96'd0, 32'd7});
    idle(3);

    // five back-to-back requests with valid held
    burst[0] = '{2'd0, 32'd1, 0};
    burst[1] = '{2'd1, 32'd10, 0};
    burst[2] = '{2'd0, 32'd2, 0};
    burst[3] = '{2'd2, 32'd20, 0};
    burst[4] = '{2'd3, 32'd30, 0};
    idx = 0;
    budget = 40;
    while (idx < 5 && budget > 0) begin
      acc = (mq.size() < DEPTH);
      cycle(1'b1, burst[idx].chan, burst[idx].data, 8'(burst[idx].delay), 1'b0);
      if (acc) idx++;
      budget--;
    end
    chk("burst_accepted", 128'(idx), 128'd5);
    idle(8);
    chk("ch0_last_wins", {96'd0, out_data4[31:0]}, {96'd0, 32'd2});

    // out-of-range channel on the 3-channel instance
    cycle(1'b1, 2'd3, 32'd9, 8'd0, 1'b0);
    idle(2);
    chk("err3_pulse", {127'd0, err3}, 128'd1);
    idle(3);

    // reload during WAIT
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 32'(100 + i), 8'd3, 1'b0);
    idle(1);
    cycle(1'b1, 2'd0, 32'hdead, 8'd0, 1'b1);
    chk("reload_pulse", {124'd0, out_changed4}, {124'd0, 4'b1111});
    idle(10);

    // asynchronous reset during WAIT
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 32'(200 + i), 8'd3, 1'b0);
    idle(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_busy", {127'd0, busy4}, 128'd0);
    chk("rst_ready", {127'd0, wr_ready4}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            8'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
